// File: rtl/tb_snf_chi_ctrl_if.sv
// NoC-facing CHI channels of the SN-F controller: REQ and write DAT in,
// RSP and read DAT out. SRAM and error signals stay on the module itself.
interface tb_snf_chi_ctrl_if #(
  parameter int ADDR_W   = 44,
  parameter int DATA_W   = 512,
  parameter int TXNID_W  = 12,
  parameter int NODEID_W = 11
);
  // Every channel: a flit transfers on a clock edge where valid & ready are
  // both 1. A sender never drops valid or changes the flit until ready is seen.
  logic                req_valid;
  logic                req_ready;
  logic [6:0]          req_opcode;
  logic [ADDR_W-1:0]   req_addr;
  logic [TXNID_W-1:0]  req_txnid;
  logic [NODEID_W-1:0] req_srcid;

  logic                wdat_valid;
  logic                wdat_ready;
  logic [3:0]          wdat_opcode;
  logic [TXNID_W-1:0]  wdat_txnid;
  logic [DATA_W-1:0]   wdat_data;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [3:0]          rsp_opcode;
  logic [NODEID_W-1:0] rsp_tgtid;
  logic [TXNID_W-1:0]  rsp_txnid;
  logic [TXNID_W-1:0]  rsp_dbid;
  logic [1:0]          rsp_resperr;

  logic                rdat_valid;
  logic                rdat_ready;
  logic [3:0]          rdat_opcode;
  logic [NODEID_W-1:0] rdat_tgtid;
  logic [TXNID_W-1:0]  rdat_txnid;
  logic [DATA_W-1:0]   rdat_data;

  modport master (
    output req_valid, req_opcode, req_addr, req_txnid, req_srcid,
    input  req_ready,
    output wdat_valid, wdat_opcode, wdat_txnid, wdat_data,
    input  wdat_ready,
    input  rsp_valid, rsp_opcode, rsp_tgtid, rsp_txnid, rsp_dbid, rsp_resperr,
    output rsp_ready,
    input  rdat_valid, rdat_opcode, rdat_tgtid, rdat_txnid, rdat_data,
    output rdat_ready
  );

  modport slave (
    input  req_valid, req_opcode, req_addr, req_txnid, req_srcid,
    output req_ready,
    input  wdat_valid, wdat_opcode, wdat_txnid, wdat_data,
    output wdat_ready,
    output rsp_valid, rsp_opcode, rsp_tgtid, rsp_txnid, rsp_dbid, rsp_resperr,
    input  rsp_ready,
    output rdat_valid, rdat_opcode, rdat_tgtid, rdat_txnid, rdat_data,
    input  rdat_ready
  );
endinterface

// File: rtl/tb_snf_chi_ctrl.sv
// CHI SN-F controller: serves ReadNoSnp / WriteNoSnpFull one at a time against
// a single-port SRAM and answers anything else with an NDERR Comp.
module tb_snf_chi_ctrl #(
  parameter int ADDR_W   = 44,
  parameter int DATA_W   = 512,
  parameter int TXNID_W  = 12,
  parameter int NODEID_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  tb_snf_chi_ctrl_if.slave  noc,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  output logic [DATA_W-1:0] sram_wr_data,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic              proto_err,
  output logic [2:0]        state_dbg
);
  localparam logic [6:0] OP_READ_NO_SNP  = 7'h04;
  localparam logic [6:0] OP_WRITE_NS_FUL = 7'h1D;
  localparam logic [3:0] RSP_COMP        = 4'h4;
  localparam logic [3:0] RSP_COMP_DBID   = 4'h5;
  localparam logic [3:0] DAT_NCB_WR      = 4'h3;
  localparam logic [3:0] DAT_COMP_DATA   = 4'h4;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, RD_SEND, WR_DBID, WR_DATA, WR_COMMIT, ERR_RSP
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cap_addr;
  logic [TXNID_W-1:0]  cap_txnid;
  logic [NODEID_W-1:0] cap_srcid;
  logic [DATA_W-1:0]   rd_data_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                err_n;
  logic                req_hs;
  logic                wdat_good;

  // The opcode is decoded at the handshake; the resulting state carries it.
  assign req_hs    = (state == IDLE) && !rst && noc.req_valid;
  assign wdat_good = (noc.wdat_opcode == DAT_NCB_WR) && (noc.wdat_txnid == cap_txnid);

  always_comb begin
    state_n         = state;
    err_n           = 1'b0;
    noc.req_ready   = 1'b0;
    noc.wdat_ready  = 1'b0;
    noc.rsp_valid   = 1'b0;
    noc.rsp_opcode  = 4'h0;
    noc.rsp_resperr = 2'b00;
    noc.rdat_valid  = 1'b0;
    sram_rd_en      = 1'b0;
    sram_wr_en      = 1'b0;
    sram_addr       = '0;
    case (state)
      IDLE: begin
        noc.req_ready = !rst;
        if (req_hs) begin
          case (noc.req_opcode)
            OP_READ_NO_SNP:  state_n = RD_ISSUE;
            OP_WRITE_NS_FUL: state_n = WR_DBID;
            default: begin
              state_n = ERR_RSP;
              err_n   = 1'b1;
            end
          endcase
        end
      end
      RD_ISSUE: begin
        sram_rd_en = 1'b1;
        sram_addr  = cap_addr;
        state_n    = RD_WAIT;
      end
      RD_WAIT: state_n = RD_SEND;
      RD_SEND: begin
        noc.rdat_valid = 1'b1;
        if (noc.rdat_ready) state_n = IDLE;
      end
      WR_DBID: begin
        noc.rsp_valid  = 1'b1;
        noc.rsp_opcode = RSP_COMP_DBID;
        if (noc.rsp_ready) state_n = WR_DATA;
      end
      WR_DATA: begin
        noc.wdat_ready = 1'b1;
        if (noc.wdat_valid) begin
          if (wdat_good) state_n = WR_COMMIT;
          else           err_n   = 1'b1;
        end
      end
      WR_COMMIT: begin
        sram_wr_en = 1'b1;
        sram_addr  = cap_addr;
        state_n    = IDLE;
      end
      ERR_RSP: begin
        noc.rsp_valid   = 1'b1;
        noc.rsp_opcode  = RSP_COMP;
        noc.rsp_resperr = 2'b11;
        if (noc.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      proto_err <= 1'b0;
      cap_addr  <= '0;
      cap_txnid <= '0;
      cap_srcid <= '0;
      rd_data_q <= '0;
      wr_data_q <= '0;
    end else begin
      state     <= state_n;
      proto_err <= err_n;
      if (req_hs) begin
        cap_addr  <= noc.req_addr;
        cap_txnid <= noc.req_txnid;
        cap_srcid <= noc.req_srcid;
      end
      if (state == RD_WAIT) rd_data_q <= sram_rd_data;
      if ((state == WR_DATA) && noc.wdat_valid && wdat_good) wr_data_q <= noc.wdat_data;
    end
  end

  assign noc.rsp_tgtid   = cap_srcid;
  assign noc.rsp_txnid   = cap_txnid;
  assign noc.rsp_dbid    = cap_txnid;
  assign noc.rdat_opcode = DAT_COMP_DATA;
  assign noc.rdat_tgtid  = cap_srcid;
  assign noc.rdat_txnid  = cap_txnid;
  assign noc.rdat_data   = rd_data_q;
  assign sram_wr_data    = wr_data_q;
  assign state_dbg       = state;
endmodule
